// File: rtl/up_down_pkg.sv
// Shared types and constants for the up/down counter sequencer.
package up_down_pkg;

    localparam int   CNT_W     = 4;
    localparam int   CNT_MAX   = 7;
    localparam logic MODE_UP   = 1'b1;
    localparam logic MODE_DOWN = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_UP,
        ST_DWELL,
        ST_DOWN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/up_down_step_timer.sv
// Loadable down-counter with a zero flag; times the UP, DWELL and DOWN phases.
module up_down_step_timer #(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [TW-1:0] i_load_val,
    input  logic          i_dec,
    output logic          o_zero
);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - TW'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/up_down_seq_ctrl.sv
// Sequencer driving clear/up/dwell/down passes of the wrapping up/down counter.
// Optional counter self-check is built when SELF_CHECK_EN is defined.
module up_down_seq_ctrl
    import up_down_pkg::*;
#(
    parameter int W         = CNT_W,
    parameter int MAX_STATE = CNT_MAX,
    parameter int DWELL_CYC = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] up_steps,
    input  logic [W-1:0] down_steps,
    input  logic [2:0]   passes,
    input  logic [W-1:0] cnt_value,
    output logic         ctr_rst,
    output logic         ctr_en,
    output logic         ctr_mode,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int DW_W = $clog2(DWELL_CYC + 1);
    localparam int TW   = (W > DW_W) ? W : DW_W;
    localparam logic [TW-1:0] DWELL_LOAD = TW'(DWELL_CYC - 1);

    state_t        r_state, w_state_nx;
    logic [W-1:0]  r_up_lat, r_down_lat;
    logic [2:0]    r_passes_lat, r_pass_idx;
    logic [2:0]    w_passes_eff;
    logic          w_more;
    logic          w_accept, w_pass_inc;
    logic          w_tmr_load, w_tmr_dec, w_tmr_zero;
    logic [TW-1:0] w_tmr_val;
    state_t        w_up_state;
    logic [TW-1:0] w_up_load;

    up_down_step_timer #(.TW(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    assign w_passes_eff = (r_passes_lat == 3'd0) ? 3'd1 : r_passes_lat;
    assign w_more       = (r_pass_idx < (w_passes_eff - 3'd1));
    // A zero-length UP phase falls straight through to DWELL.
    assign w_up_state   = (r_up_lat == '0) ? ST_DWELL : ST_UP;
    assign w_up_load    = (r_up_lat == '0) ? DWELL_LOAD : TW'(r_up_lat - W'(1));

    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_pass_inc = 1'b0;
        w_tmr_load = 1'b0;
        w_tmr_dec  = 1'b0;
        w_tmr_val  = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nx = ST_CLR;
                    w_accept   = 1'b1;
                end
            end
            ST_CLR: begin
                w_state_nx = w_up_state;
                w_tmr_load = 1'b1;
                w_tmr_val  = w_up_load;
            end
            ST_UP: begin
                if (w_tmr_zero) begin
                    w_state_nx = ST_DWELL;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = DWELL_LOAD;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            ST_DWELL: begin
                if (!w_tmr_zero) begin
                    w_tmr_dec = 1'b1;
                end else if (down_nonzero()) begin
                    w_state_nx = ST_DOWN;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = TW'(r_down_lat - W'(1));
                end else if (w_more) begin
                    w_state_nx = w_up_state;
                    w_pass_inc = 1'b1;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = w_up_load;
                end else begin
                    w_state_nx = ST_DONE;
                end
            end
            ST_DOWN: begin
                if (!w_tmr_zero) begin
                    w_tmr_dec = 1'b1;
                end else if (w_more) begin
                    w_state_nx = w_up_state;
                    w_pass_inc = 1'b1;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = w_up_load;
                end else begin
                    w_state_nx = ST_DONE;
                end
            end
            ST_DONE:  w_state_nx = ST_IDLE;
            default:  w_state_nx = ST_IDLE;
        endcase
        // Abort beats everything, including a simultaneous start in IDLE.
        if (abort) begin
            w_state_nx = ST_IDLE;
            w_accept   = 1'b0;
            w_pass_inc = 1'b0;
            w_tmr_load = 1'b0;
            w_tmr_dec  = 1'b0;
        end
    end

    function automatic logic down_nonzero();
        return (r_down_lat != '0);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            ctr_rst      <= 1'b0;
            ctr_en       <= 1'b0;
            ctr_mode     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            r_up_lat     <= '0;
            r_down_lat   <= '0;
            r_passes_lat <= '0;
            r_pass_idx   <= '0;
        end else begin
            // Outputs are decoded from the next state so they line up with it.
            r_state  <= w_state_nx;
            ctr_rst  <= (w_state_nx == ST_CLR);
            ctr_en   <= (w_state_nx == ST_UP) || (w_state_nx == ST_DOWN);
            busy     <= (w_state_nx == ST_CLR) || (w_state_nx == ST_UP) ||
                        (w_state_nx == ST_DWELL) || (w_state_nx == ST_DOWN);
            done     <= (w_state_nx == ST_DONE);
            if (w_state_nx == ST_UP) begin
                ctr_mode <= MODE_UP;
            end else if (w_state_nx == ST_DOWN) begin
                ctr_mode <= MODE_DOWN;
            end
            if (w_accept) begin
                r_up_lat     <= up_steps;
                r_down_lat   <= down_steps;
                r_passes_lat <= passes;
                r_pass_idx   <= '0;
            end else if (w_pass_inc) begin
                r_pass_idx   <= r_pass_idx + 3'd1;
            end
        end
    end

`ifdef SELF_CHECK_EN
    logic [W-1:0] r_exp_val, w_exp_nx;
    logic         r_err;

    always_comb begin
        w_exp_nx = r_exp_val;
        if (ctr_rst) begin
            w_exp_nx = '0;
        end else if (ctr_en && (ctr_mode == MODE_UP)) begin
            w_exp_nx = (r_exp_val == W'(MAX_STATE)) ? '0 : r_exp_val + W'(1);
        end else if (ctr_en) begin
            w_exp_nx = (r_exp_val == '0) ? W'(MAX_STATE) : r_exp_val - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exp_val <= '0;
            r_err     <= 1'b0;
        end else begin
            r_exp_val <= w_exp_nx;
            if (w_accept) begin
                r_err <= 1'b0;
            end else if (busy && !ctr_rst && (cnt_value != r_exp_val)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    logic w_unused_chk;
    assign w_unused_chk = ^{cnt_value, W'(MAX_STATE)};
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_up_down_seq_ctrl.sv
// Directed bench for up_down_seq_ctrl: models the counter datapath and checks
// every output cycle against a sequence-level expectation queue.
module tb_up_down_seq_ctrl;

    localparam int W    = 4;
    localparam int MAXS = 7;
    localparam int DW   = 2;

    logic         clk = 1'b0;
    logic         rst, start, abort;
    logic [W-1:0] up_steps, down_steps;
    logic [2:0]   passes;
    logic [W-1:0] cnt_value;
    logic         ctr_rst, ctr_en, ctr_mode, busy, done, err;
    logic         stuck;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int clr_cnt = 0;
    int done_cyc = 0;

    always #5 clk = ~clk;

    up_down_seq_ctrl #(.W(W), .MAX_STATE(MAXS), .DWELL_CYC(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .up_steps   (up_steps),
        .down_steps (down_steps),
        .passes     (passes),
        .cnt_value  (cnt_value),
        .ctr_rst    (ctr_rst),
        .ctr_en     (ctr_en),
        .ctr_mode   (ctr_mode),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Counter datapath stand-in; 'stuck' forces a broken counter.
    always @(posedge clk) begin
        if (rst || stuck || ctr_rst) cnt_value <= '0;
        else if (ctr_en) cnt_value <= W'((int'(cnt_value) + (ctr_mode ? 1 : MAXS)) % (MAXS + 1));
    end

    // Expected per-cycle behaviour, generated from the phase lengths.
    typedef struct packed { logic r; logic en; logic m; logic b; logic d; } ev_t;
    ev_t  q[$];
    logic e_valid = 1'b0;
    logic e_rst = 1'b0, e_en = 1'b0, e_mode = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
    logic err_hit = 1'b0;
    int   ideal = 0;

    function automatic void build_seq(input int u, input int d, input int p);
        int np;
        np = (p == 0) ? 1 : p;
        q.push_back('{r:1'b1, en:1'b0, m:1'b0, b:1'b1, d:1'b0});
        for (int i = 0; i < np; i++) begin
            for (int k = 0; k < u; k++)  q.push_back('{r:1'b0, en:1'b1, m:1'b1, b:1'b1, d:1'b0});
            for (int k = 0; k < DW; k++) q.push_back('{r:1'b0, en:1'b0, m:1'b0, b:1'b1, d:1'b0});
            for (int k = 0; k < d; k++)  q.push_back('{r:1'b0, en:1'b1, m:1'b0, b:1'b1, d:1'b0});
        end
        q.push_back('{r:1'b0, en:1'b0, m:1'b0, b:1'b0, d:1'b1});
    endfunction

    initial begin : model
        ev_t ev;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                q.delete();
                {e_rst, e_en, e_mode, e_busy, e_done, e_err} = '0;
                ideal   = 0;
                e_valid = 1'b1;
            end else if (e_valid) begin
`ifdef SELF_CHECK_EN
                if (err_hit) e_err = 1'b1;
`endif
                if (e_rst) ideal = 0;
                else if (e_en) ideal = (ideal + (e_mode ? 1 : MAXS)) % (MAXS + 1);
                if ((e_busy || e_done) && abort) begin
                    q.delete();
                    {e_rst, e_en, e_busy, e_done} = '0;
                end else if (q.size() > 0 || (!e_busy && !e_done && start && !abort)) begin
                    if (q.size() == 0) begin
                        build_seq(int'(up_steps), int'(down_steps), int'(passes));
                        e_err = 1'b0;
                    end
                    ev = q.pop_front();
                    e_rst = ev.r; e_en = ev.en; e_busy = ev.b; e_done = ev.d;
                    if (ev.en) e_mode = ev.m;
                end else begin
                    {e_rst, e_en, e_busy, e_done} = '0;
                end
            end
        end
    end

    initial begin : compare
        logic [5:0] got, want;
        forever begin
            @(negedge clk);
            if (e_valid) begin
                got  = {ctr_rst, ctr_en, ctr_mode, busy, done, err};
                want = {e_rst, e_en, e_mode, e_busy, e_done, e_err};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d {rst,en,mode,busy,done,err} got %b expected %b", cyc, got, want);
                end
                err_hit = e_busy && !e_rst && (int'(cnt_value) != ideal);
                if (done)    begin done_cnt++; done_cyc = cyc; end
                if (ctr_rst) clr_cnt++;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int d0, input string name);
        for (int i = 0; i < 200 && done_cnt == d0; i++) tick(1);
        if (done_cnt == d0) check({name, "_timeout"}, 0, 1);
        else tick(1);
    endtask

    task automatic load(input int u, input int d, input int p);
        up_steps = W'(u); down_steps = W'(d); passes = 3'(p);
    endtask

    task automatic run_seq(input int u, input int d, input int p, input int len, input int fin, input string name);
        int d0, c0, t0;
        load(u, d, p);
        d0 = done_cnt; c0 = clr_cnt; t0 = cyc;
        start = 1'b1; tick(1); start = 1'b0;
        wait_done(d0, name);
        check({name, "_latency"}, done_cyc - t0, len);
        check({name, "_final_cnt"}, int'(cnt_value), fin);
        check({name, "_done_pulses"}, done_cnt - d0, 1);
        check({name, "_clr_pulses"}, clr_cnt - c0, 1);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t0, d0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; stuck = 1'b0;
        load(0, 0, 0);
        tick(3);
        check("reset_outputs", int'({ctr_rst, ctr_en, ctr_mode, busy, done, err}), 0);
        rst = 1'b0;
        tick(2);

        run_seq(5, 3, 1, 12, 2, "t1_basic");
        run_seq(9, 0, 1, 13, 1, "t2_upwrap");
        run_seq(2, 1, 3, 17, 3, "t3_passes");
        run_seq(1, 2, 0, 7, 7, "pass0_downwrap");

        // Abort on the third UP cycle.
        load(5, 3, 1); d0 = done_cnt; t0 = cyc;
        start = 1'b1; tick(1); start = 1'b0;
        check("t4_clr_cycle", int'({ctr_rst, ctr_en, busy}), 3'b101);
        tick(1);
        check("t4_first_en", int'({ctr_en, ctr_mode}), 2'b11);
        tick(2);
        abort = 1'b1; tick(1); abort = 1'b0;
        check("t4_abort_idle", int'({busy, ctr_en}), 0);
        tick(3);
        check("t4_cnt_held", int'(cnt_value), 3);
        check("t4_no_done", done_cnt - d0, 0);

        // Start during DWELL is ignored; rst during DOWN clears outputs.
        load(5, 3, 1); t0 = cyc;
        start = 1'b1; tick(1); start = 1'b0;
        tick(6);
        load(1, 1, 2); start = 1'b1; tick(1); start = 1'b0; load(5, 3, 1);
        tick(2);
        rst = 1'b1; tick(1); rst = 1'b0;
        check("t5_rst_outputs", int'({ctr_rst, ctr_en, ctr_mode, busy, done, err}), 0);
        tick(2);
        run_seq(5, 3, 1, 12, 2, "t5_restart");

        // Abort and start together in IDLE: abort wins.
        start = 1'b1; abort = 1'b1; tick(1); start = 1'b0; abort = 1'b0;
        check("abort_start_idle", int'({busy, ctr_rst}), 0);
        tick(2);

        // Start during the DONE cycle is ignored.
        load(1, 1, 1); t0 = cyc;
        start = 1'b1; tick(1); start = 1'b0;
        tick(5);
        check("done_cycle_pulse", int'({done, busy}), 2'b10);
        start = 1'b1; tick(1); start = 1'b0;
        check("start_in_done_ignored", int'({busy, ctr_rst}), 0);
        tick(3);

`ifdef SELF_CHECK_EN
        stuck = 1'b1; load(2, 0, 1); d0 = done_cnt;
        start = 1'b1; tick(1); start = 1'b0;
        tick(2);
        check("t6_err_before", int'(err), 0);
        tick(1);
        check("t6_err_set", int'(err), 1);
        wait_done(d0, "t6_stuck");
        check("t6_err_sticky", int'(err), 1);
        stuck = 1'b0; load(1, 0, 1); d0 = done_cnt;
        start = 1'b1; tick(1); start = 1'b0;
        check("t6_err_cleared", int'(err), 0);
        wait_done(d0, "t6_clean");
`endif

        tick(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
